// File: rtl/mac_accumulator_pkg.sv
// rtl/mac_accumulator_pkg.sv - shared state encoding and width helper for the convolution datapath
package mac_accumulator_pkg;

  // Window accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_e;

  // Width of the counter octet exposed on o_count
  localparam int COUNT_WIDTH = 8;

  // Ceiling log2, usable in parameter expressions; clog2(0) and clog2(1) are 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result = 0;
    if (value > 1) begin
      remaining = value - 1;
      while (remaining > 0) begin
        result    = result + 1;
        remaining = remaining >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product in / window sum out handshake bundle
interface mac_accumulator_if #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 20
);

  logic [2*BIT_WIDTH-1:0] i_product;
  logic                   i_product_valid;
  logic                   i_clear;
  logic                   i_sum_ready;
  logic [ACC_WIDTH-1:0]   o_sum;
  logic                   o_sum_valid;
  logic                   o_busy;
  logic [7:0]             o_count;
  logic                   o_overrun;

  // Upstream/downstream side: drives products, clear and ready
  modport master (
    output i_product, i_product_valid, i_clear, i_sum_ready,
    input  o_sum, o_sum_valid, o_busy, o_count, o_overrun
  );

  // Accumulator side
  modport slave (
    input  i_product, i_product_valid, i_clear, i_sum_ready,
    output o_sum, o_sum_valid, o_busy, o_count, o_overrun
  );

endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums KERNEL_SIZE products per window and holds the result until accepted
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mac_accumulator_if.slave   bus
);

  localparam int PROD_WIDTH = 2 * BIT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(KERNEL_SIZE - 1);

  // Reject configurations whose sum could wrap or whose count cannot fit the counter
  generate
    if (ACC_WIDTH < PROD_WIDTH + clog2(KERNEL_SIZE)) begin : g_acc_width_check
      $error("mac_accumulator: ACC_WIDTH too narrow for BIT_WIDTH and KERNEL_SIZE");
    end
    if (KERNEL_SIZE < 1 || KERNEL_SIZE > 255) begin : g_kernel_size_check
      $error("mac_accumulator: KERNEL_SIZE must be within 1..255");
    end
  endgenerate

  mac_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic                   overrun_q, overrun_d;

  logic [ACC_WIDTH-1:0]   product_ext;
  logic [ACC_WIDTH-1:0]   acc_plus;
  logic                   start_window;

  assign product_ext = ACC_WIDTH'(bus.i_product);
  assign acc_plus    = acc_q + product_ext;

  // Next-state: clear dominates, then per-state window handling; a window start is shared by IDLE and HOLD
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    sum_d        = sum_q;
    sum_valid_d  = sum_valid_q;
    overrun_d    = overrun_q;
    start_window = 1'b0;

    if (bus.i_clear) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      count_d     = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          start_window = bus.i_product_valid;
        end
        ST_ACCUM: begin
          if (bus.i_product_valid) begin
            if (count_q == LAST_COUNT) begin
              sum_d       = acc_plus;
              sum_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
              state_d     = ST_HOLD;
            end else begin
              acc_d   = acc_plus;
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.i_sum_ready) begin
            sum_valid_d  = 1'b0;
            state_d      = ST_IDLE;
            start_window = bus.i_product_valid;
          end else if (bus.i_product_valid) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          count_d     = '0;
          sum_valid_d = 1'b0;
        end
      endcase

      // A single-product kernel completes on its first product
      if (start_window) begin
        if (KERNEL_SIZE == 1) begin
          sum_d       = product_ext;
          sum_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = ST_HOLD;
        end else begin
          acc_d   = product_ext;
          count_d = COUNT_WIDTH'(1);
          state_d = ST_ACCUM;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously so partial windows are abandoned at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_sum       = sum_q;
  assign bus.o_sum_valid = sum_valid_q;
  assign bus.o_count     = count_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state_q == ST_HOLD) & ~bus.i_sum_ready;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator
module tb_mac_accumulator;

  logic clk;
  logic rst_n;

  mac_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(20)) bus ();
  mac_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(20)) bus1 ();

  mac_accumulator #(.BIT_WIDTH(8), .KERNEL_SIZE(9), .ACC_WIDTH(20)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  mac_accumulator #(.BIT_WIDTH(8), .KERNEL_SIZE(1), .ACC_WIDTH(20)) dut_k1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int unsigned base;
    int unsigned step;
    int unsigned delay;
    int unsigned exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n back-to-back products base, base+step, ... without checking
  task automatic feed(input int unsigned base, input int unsigned step, input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      bus.i_product_valid = 1'b1;
      bus.i_product       = 16'(base + i * step);
      bus.i_sum_ready     = ready;
      tick();
    end
    bus.i_product_valid = 1'b0;
    bus.i_sum_ready     = 1'b0;
  endtask

  // One full window from IDLE, ready held off for 'delay' cycles after completion
  task automatic run_window(input int unsigned base, input int unsigned step,
                            input int unsigned delay, input int unsigned exp_sum);
    for (int i = 0; i < 9; i++) begin
      bus.i_product_valid = 1'b1;
      bus.i_product       = 16'(base + i * step);
      bus.i_sum_ready     = (delay == 0);
      tick();
      if (i < 8) begin
        check("win_count", bus.o_count, i + 1);
        check("win_valid_early", bus.o_sum_valid, 0);
      end
    end
    bus.i_product_valid = 1'b0;
    check("win_valid", bus.o_sum_valid, 1);
    check("win_sum", bus.o_sum, exp_sum);
    check("win_count_zero", bus.o_count, 0);
    for (int d = 0; d < int'(delay); d++) begin
      bus.i_sum_ready = 1'b0;
      #1;
      check("hold_busy", bus.o_busy, 1);
      tick();
      check("hold_valid", bus.o_sum_valid, 1);
      check("hold_sum", bus.o_sum, exp_sum);
    end
    bus.i_sum_ready = 1'b1;
    #1;
    check("accept_busy", bus.o_busy, 0);
    tick();
    check("accept_valid", bus.o_sum_valid, 0);
    bus.i_sum_ready = 1'b0;
  endtask

  initial begin
    int unsigned m_sum, m_count, m_out;
    bit m_pend, m_ovr;
    logic v, r, c;
    logic [15:0] p;

    vecs[0] = '{65025, 0, 0, 585225};
    vecs[1] = '{1, 1, 5, 45};
    vecs[2] = '{2, 0, 0, 18};
    vecs[3] = '{1, 0, 2, 9};
    vecs[4] = '{100, 3, 1, 1008};
    vecs[5] = '{1000, 1000, 3, 45000};
    vecs[6] = '{65535, 0, 0, 589815};

    rst_n = 1'b0;
    bus.i_product = '0;  bus.i_product_valid = 1'b0; bus.i_clear = 1'b0; bus.i_sum_ready = 1'b0;
    bus1.i_product = '0; bus1.i_product_valid = 1'b0; bus1.i_clear = 1'b0; bus1.i_sum_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", bus.o_sum, 0);
    check("rst_valid", bus.o_sum_valid, 0);
    check("rst_count", bus.o_count, 0);
    check("rst_overrun", bus.o_overrun, 0);
    check("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) run_window(vecs[k].base, vecs[k].step, vecs[k].delay, vecs[k].exp_sum);

    // Product in HOLD with ready low is dropped and flagged
    feed(1, 1, 9, 1'b0);
    bus.i_product_valid = 1'b1; bus.i_product = 16'd7; bus.i_sum_ready = 1'b0;
    #1;
    check("drop_busy", bus.o_busy, 1);
    tick();
    bus.i_product_valid = 1'b0;
    check("drop_overrun", bus.o_overrun, 1);
    check("drop_sum", bus.o_sum, 45);
    check("drop_valid", bus.o_sum_valid, 1);
    check("drop_count", bus.o_count, 0);
    bus.i_sum_ready = 1'b1;
    tick();
    bus.i_sum_ready = 1'b0;
    run_window(1, 1, 0, 45);
    check("overrun_sticky", bus.o_overrun, 1);

    // Ready and a new product together: sum accepted and the product opens the next window
    feed(1, 1, 9, 1'b0);
    check("pre_accept_sum", bus.o_sum, 45);
    bus.i_sum_ready = 1'b1; bus.i_product_valid = 1'b1; bus.i_product = 16'd100;
    tick();
    bus.i_sum_ready = 1'b0; bus.i_product_valid = 1'b0;
    check("same_cycle_valid", bus.o_sum_valid, 0);
    check("same_cycle_count", bus.o_count, 1);
    feed(5, 0, 8, 1'b0);
    check("next_window_valid", bus.o_sum_valid, 1);
    check("next_window_sum", bus.o_sum, 140);
    bus.i_sum_ready = 1'b1;
    tick();
    bus.i_sum_ready = 1'b0;

    // Clear mid-window, with a same-cycle product that must be ignored
    feed(3, 0, 4, 1'b0);
    check("pre_clear_count", bus.o_count, 4);
    bus.i_clear = 1'b1; bus.i_product_valid = 1'b1; bus.i_product = 16'd9;
    tick();
    bus.i_clear = 1'b0; bus.i_product_valid = 1'b0;
    check("clear_count", bus.o_count, 0);
    check("clear_overrun", bus.o_overrun, 0);
    check("clear_valid", bus.o_sum_valid, 0);
    run_window(2, 0, 0, 18);

    // Single-product kernel
    bus1.i_product_valid = 1'b1; bus1.i_product = 16'd300;
    tick();
    bus1.i_product_valid = 1'b0;
    check("k1_valid", bus1.o_sum_valid, 1);
    check("k1_sum", bus1.o_sum, 300);
    check("k1_count", bus1.o_count, 0);
    bus1.i_sum_ready = 1'b1;
    tick();
    bus1.i_sum_ready = 1'b0;
    check("k1_accept", bus1.o_sum_valid, 0);

    // Half-cycle asynchronous reset mid-window
    feed(1, 0, 5, 1'b0);
    check("pre_reset_count", bus.o_count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", bus.o_count, 0);
    check("async_rst_valid", bus.o_sum_valid, 0);
    #2 rst_n = 1'b1;
    run_window(1, 0, 0, 9);

    // Random traffic against a window-level model
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    m_sum = 0; m_count = 0; m_out = 0; m_pend = 0; m_ovr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 63) == 0);
      p = 16'($urandom_range(0, 65535));
      bus.i_product_valid = v; bus.i_sum_ready = r; bus.i_clear = c; bus.i_product = p;
      #1;
      check("rnd_busy", bus.o_busy, m_pend & ~r);
      if (c) begin
        m_sum = 0; m_count = 0; m_pend = 0; m_ovr = 0;
      end else begin
        bit blocked;
        blocked = m_pend & ~r;
        if (m_pend && r) m_pend = 0;
        if (v) begin
          if (blocked) m_ovr = 1;
          else begin
            m_sum = (m_count == 0) ? p : m_sum + p;
            m_count++;
            if (m_count == 9) begin
              m_pend = 1; m_out = m_sum; m_count = 0;
            end
          end
        end
      end
      tick();
      check("rnd_valid", bus.o_sum_valid, m_pend);
      check("rnd_count", bus.o_count, m_count);
      check("rnd_overrun", bus.o_overrun, m_ovr);
      if (m_pend) check("rnd_sum", bus.o_sum, m_out);
    end
    bus.i_product_valid = 1'b0; bus.i_sum_ready = 1'b0; bus.i_clear = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
